spi_flash_ctrl: RTL and testbench

Read-only SPI NOR flash controller that sits directly downstream of the digital_soc flash port. It serves the SoC's byte-wide flash requests (address, read enable, ready) by issuing standard SPI READ (0x03) transactions in mode 0. Each returned byte is presented on flash_data together with flash_ready. It replaces the behavioural flash model on the path to a real external flash part.

---
 rtl/spi_flash_pkg.sv | 32 +++
 rtl/spi_shift_engine.sv | 78 +++++++
 rtl/spi_flash_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_spi_flash_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI NOR read controller.
// SPI_FLASH_SEQ_READ_EN adds the HOLD state used for sequential bursts.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam int         CMD_ADDR_BITS = 32;
  localparam int         DATA_BITS     = 8;
  localparam int         XFER_BITS     = CMD_ADDR_BITS + DATA_BITS;
  localparam int         FA_BITS       = CMD_ADDR_BITS - 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CSGAP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
`ifdef SPI_FLASH_SEQ_READ_EN
    , ST_HOLD = 3'd4
`endif
  } fsm_state_t;

  // One request to the shift engine: full command+address frame, or
  // data-only continuation of an open burst.
  typedef struct packed {
    logic               seq;
    logic [FA_BITS-1:0] addr;
  } shift_req_t;

  function automatic logic [CMD_ADDR_BITS-1:0] read_header(input logic [FA_BITS-1:0] a);
    return {CMD_READ, a};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: clock divider, SCLK generation, MSB-first shift
// out of command/address and sampling of the returned byte.
module spi_shift_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  shift_req_t req,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]     div_cnt;
  logic [5:0]           bits_left;
  logic [XFER_BITS-1:0] sreg;
  logic                 busy;
  logic                 half_end;

  assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Asserted in the cycle whose closing edge drops SCLK after the last bit.
  assign done     = busy && half_end && sclk && (bits_left == 6'd1);

  // Divider, SCLK phase, shift register and receive byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      sreg      <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rx_byte   <= 8'h00;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      sclk    <= 1'b0;
      if (req.seq) begin
        sreg      <= '0;
        bits_left <= 6'(DATA_BITS);
        mosi      <= 1'b0;
      end else begin
        sreg      <= {read_header(req.addr), 8'h00};
        bits_left <= 6'(XFER_BITS);
        mosi      <= read_header(req.addr)[CMD_ADDR_BITS-1];
      end
    end else if (busy) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!sclk) begin
          // Rising SCLK: the flash has held its bit since the last fall.
          sclk    <= 1'b1;
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          sclk <= 1'b0;
          if (bits_left == 6'd1) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            bits_left <= bits_left - 6'd1;
            sreg      <= {sreg[XFER_BITS-2:0], 1'b0};
            mosi      <= sreg[XFER_BITS-2];
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_ctrl.sv
// Read-only SPI NOR flash controller behind the SoC byte flash port.
// Issues READ (0x03) frames; writes are acknowledged and dropped.
// Define SPI_FLASH_SEQ_READ_EN to keep CS low across sequential bytes.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLASH_ADDR_W = 24,
  parameter int CLK_DIV      = 2,
  parameter int CS_HIGH_MIN  = 2,
  parameter int SEQ_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_read_en,
  input  logic              flash_write_en,
  output logic [7:0]        flash_data,
  output logic              flash_ready,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  fsm_state_t              state, state_n;
  logic [FLASH_ADDR_W-1:0] lat_addr;
  logic [FLASH_ADDR_W-1:0] req_addr;
  logic                    addr_match;
  logic                    ready_n, cs_n_n, start_n, seq_n, latch, load;
  logic                    start_r, seq_r;
  logic [7:0]              gap_cnt, gap_n;
  logic                    eng_done;
  logic [7:0]              eng_rx;
  shift_req_t              eng_req;

  // SoC address bits above the flash window are don't-care.
  logic unused_hi_addr;
  assign unused_hi_addr = ^flash_addr[ADDR_W-1:FLASH_ADDR_W];

  assign req_addr   = flash_addr[FLASH_ADDR_W-1:0];
  assign addr_match = (req_addr == lat_addr);
  assign eng_req    = '{seq: seq_r, addr: lat_addr};

`ifdef SPI_FLASH_SEQ_READ_EN
  localparam int IDLE_W = $clog2(SEQ_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic              seq_match;
  assign seq_match = (req_addr == lat_addr + 1'b1);
`else
  localparam int unused_seq_timeout = SEQ_TIMEOUT;
`endif

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk     (clk),
    .rst     (rst),
    .start   (start_r),
    .req     (eng_req),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .done    (eng_done),
    .rx_byte (eng_rx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state, ready/CS protocol and engine kick.
  always_comb begin
    state_n = state;
    ready_n = flash_ready;
    cs_n_n  = spi_cs_n;
    start_n = 1'b0;
    seq_n   = seq_r;
    latch   = 1'b0;
    load    = 1'b0;
    gap_n   = gap_cnt;
`ifdef SPI_FLASH_SEQ_READ_EN
    idle_n  = idle_cnt;
`endif
    case (state)
      ST_IDLE: begin
        cs_n_n = 1'b1;
        if (flash_read_en && !flash_ready) begin
          state_n = ST_SHIFT;
          latch   = 1'b1;
          start_n = 1'b1;
          seq_n   = 1'b0;
          cs_n_n  = 1'b0;
          ready_n = 1'b0;
        end else begin
          // Write ack mirrors write_en; a pending read suppresses it.
          ready_n = flash_write_en && !flash_read_en;
        end
      end
      ST_SHIFT: begin
        if (eng_done) begin
          state_n = ST_DONE;
          load    = 1'b1;
          // Never flag a byte whose address the SoC has already moved off.
          ready_n = flash_read_en && addr_match;
`ifndef SPI_FLASH_SEQ_READ_EN
          cs_n_n  = 1'b1;
`endif
        end
      end
      ST_DONE: begin
        if (!flash_ready || !(flash_read_en && addr_match)) begin
          ready_n = 1'b0;
          gap_n   = 8'd0;
`ifdef SPI_FLASH_SEQ_READ_EN
          state_n = ST_HOLD;
          idle_n  = '0;
`else
          state_n = ST_CSGAP;
`endif
        end
      end
      ST_CSGAP: begin
        cs_n_n  = 1'b1;
        ready_n = 1'b0;
        if (gap_cnt >= 8'(CS_HIGH_MIN - 1)) state_n = ST_IDLE;
        else                               gap_n   = gap_cnt + 8'd1;
      end
`ifdef SPI_FLASH_SEQ_READ_EN
      ST_HOLD: begin
        ready_n = 1'b0;
        if (flash_read_en && seq_match) begin
          state_n = ST_SHIFT;
          latch   = 1'b1;
          start_n = 1'b1;
          seq_n   = 1'b1;
        end else if (flash_read_en || flash_write_en ||
                     idle_cnt == IDLE_W'(SEQ_TIMEOUT - 1)) begin
          state_n = ST_CSGAP;
          cs_n_n  = 1'b1;
          gap_n   = 8'd0;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        cs_n_n  = 1'b1;
        ready_n = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_ready <= 1'b0;
      flash_data  <= 8'h00;
      spi_cs_n    <= 1'b1;
      start_r     <= 1'b0;
      seq_r       <= 1'b0;
      lat_addr    <= '0;
      gap_cnt     <= 8'd0;
    end else begin
      flash_ready <= ready_n;
      spi_cs_n    <= cs_n_n;
      start_r     <= start_n;
      seq_r       <= seq_n;
      gap_cnt     <= gap_n;
      if (latch) lat_addr   <= req_addr;
      if (load)  flash_data <= eng_rx;
    end
  end

`ifdef SPI_FLASH_SEQ_READ_EN
  // Idle counter for closing a parked burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt <= '0;
    else      idle_cnt <= idle_n;
  end
`endif

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Scoreboard bench for spi_flash_ctrl with a behavioural SPI flash model.
module tb_spi_flash_ctrl;

  logic        clk, rst;
  logic [31:0] flash_addr;
  logic        flash_read_en, flash_write_en;
  logic [7:0]  flash_data;
  logic        flash_ready, spi_sclk, spi_cs_n, spi_mosi, spi_miso;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  spi_flash_ctrl dut (
    .clk(clk), .rst(rst), .flash_addr(flash_addr),
    .flash_read_en(flash_read_en), .flash_write_en(flash_write_en),
    .flash_data(flash_data), .flash_ready(flash_ready),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] a);
    if (a == 24'h000010) return 8'hA5;
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  // Flash model: capture the 32-bit header, then stream bytes from its address.
  logic [31:0] hdr_sh = '0;
  int          bit_cnt = 0;
  int          sclk_cnt = 0;
  int          cs_rise = 0;
  initial spi_miso = 1'b0;

  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) bit_cnt = 0;
    else begin
      if (bit_cnt < 32) hdr_sh = {hdr_sh[30:0], spi_mosi};
      bit_cnt++;
    end
  end

  always @(negedge spi_sclk) begin : drive_miso
    int k;
    logic [7:0] b;
    if (!spi_cs_n && bit_cnt >= 32) begin
      k = bit_cnt - 32;
      b = model_byte(hdr_sh[23:0] + 24'(k / 8));
      spi_miso = b[7 - (k % 8)];
    end
  end

  always @(posedge spi_sclk) sclk_cnt++;
  always @(posedge spi_cs_n) cs_rise++;

  // Scoreboard: every rising ready on a read pops one expected byte.
  logic rdy_q = 1'b0;
  bit   wr_mode = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (flash_ready && !rdy_q && !wr_mode) begin
      if (sb.size() == 0) chk("unexpected_ready", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rd_data", flash_data, e.data);
        chk("rd_addr", flash_addr[23:0], e.addr);
`ifndef SPI_FLASH_SEQ_READ_EN
        chk("rd_hdr", hdr_sh, {8'h03, e.addr});
`endif
      end
    end
    rdy_q = flash_ready;
  end

  task automatic push_exp(input logic [23:0] a);
    exp_t e;
    e.addr = a;
    e.data = model_byte(a);
    sb.push_back(e);
  endtask

  task automatic start_read(input logic [31:0] a);
    @(posedge clk); #1;
    flash_addr    = a;
    flash_read_en = 1'b1;
  endtask

  task automatic end_read();
    @(posedge clk); #1;
    flash_read_en = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // lat = index of the edge after which ready is first seen (0 = sample edge).
  task automatic wait_ready(input int max, output int lat);
    lat = -1;
    for (int k = 0; k < max; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (flash_ready) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt, s0, r0;
    rst = 1'b0;
    flash_addr = '0;
    flash_read_en = 1'b0;
    flash_write_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_ready", flash_ready, 0);
    chk("rst_data", flash_data, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single read of the known byte.
    push_exp(24'h000010);
    start_read(32'h0000_0010);
    wait_ready(400, lat);
    chk("lat_0x10", lat, 161);
`ifndef SPI_FLASH_SEQ_READ_EN
    chk("cs_n_at_ready", spi_cs_n, 1);
`endif
    end_read();

    // Back-to-back 0x0 then 0x1.
    push_exp(24'h000000);
    start_read(32'h0);
    wait_ready(400, lat);
    push_exp(24'h000001);
    @(posedge clk); #1;
    flash_addr = 32'h1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_drop", flash_ready, 0);
`ifndef SPI_FLASH_SEQ_READ_EN
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (!spi_cs_n) break;
      cnt++;
      @(negedge clk);
    end
    chk("cs_gap_ge2", (cnt >= 2), 1);
`endif
    wait_ready(400, lat);
    end_read();

    // Address changes mid-SHIFT: only byte@0x30 may be flagged.
    push_exp(24'h000030);
    start_read(32'h20);
    repeat (80) @(posedge clk);
    #1 flash_addr = 32'h30;
    wait_ready(700, lat);
    end_read();

    // Async reset at bit 20 of the frame.
    start_read(32'h40);
    repeat (81) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_cs_n", spi_cs_n, 1);
    chk("midrst_sclk", spi_sclk, 0);
    chk("midrst_ready", flash_ready, 0);
    @(negedge clk);
    flash_read_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    push_exp(24'h000055);
    start_read(32'hFF00_0055);
    wait_ready(400, lat);
    chk("lat_after_rst", lat, 161);
    end_read();

    // Unsupported write: acked while held, no SPI clocking.
    wr_mode = 1'b1;
    s0 = sclk_cnt;
    @(posedge clk); #1;
    flash_write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wr_ready", flash_ready, 1);
    @(posedge clk); #1;
    flash_write_en = 1'b0;
    @(negedge clk);
    chk("wr_ready_hold", flash_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("wr_ready_drop", flash_ready, 0);
    chk("wr_no_sclk", sclk_cnt - s0, 0);
    repeat (2) @(negedge clk);
    wr_mode = 1'b0;

    // Top of the flash window, upper SoC bits ignored.
    push_exp(24'hFFFFFF);
    start_read(32'h12FF_FFFF);
    wait_ready(400, lat);
    end_read();

`ifdef SPI_FLASH_SEQ_READ_EN
    // Sequential burst in one CS window, then idle timeout.
    push_exp(24'h000100);
    push_exp(24'h000101);
    push_exp(24'h000102);
    start_read(32'h100);
    wait_ready(400, lat);
    r0 = cs_rise;
    for (int a = 'h101; a <= 'h102; a++) begin
      @(posedge clk); #1;
      flash_addr = 32'(a);
      wait_ready(100, lat);
      // One edge for DONE to notice, then 1+16*CLK_DIV from HOLD.
      chk("seq_lat", lat, 34);
    end
    chk("seq_one_window", cs_rise - r0, 0);
    @(posedge clk); #1;
    flash_read_en = 1'b0;
    cnt = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (spi_cs_n) begin
        cnt = k;
        break;
      end
    end
    chk("seq_timeout", cnt, 16);
    repeat (8) @(posedge clk);
`else
    s0 = 0;
    r0 = 0;
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
